if_fetch_unit: RTL and testbench

Instruction-fetch stage that owns the program counter, drives the word address into `i_mem`, and registers the returned instruction into an IF/ID output register for the decode stage. It is the stage directly upstream of `i_mem`, which it feeds, and it also consumes what `i_mem` returns. It supports:
- back-pressure from decode (valid/ready);
- PC redirects from branch/jump resolution, with flush;
- a sticky fault state for misaligned or out-of-range fetch addresses.

---
 rtl/if_fetch_unit_if.sv | 42 ++++
 rtl/if_fetch_unit.sv | 113 +++++++++++
 tb/tb_if_fetch_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - fetch-stage bus: i_mem port, redirect input, IF/ID output register
interface if_fetch_unit_if;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc_plus4;
    logic        id_fault;
    logic [31:0] fetch_count;

    modport master (
        output imem_pc,
        input  imem_inst,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output id_valid,
        output id_pc,
        output id_inst,
        output id_pc_plus4,
        output id_fault,
        output fetch_count
    );

    modport slave (
        input  imem_pc,
        output imem_inst,
        output redirect_valid,
        output redirect_pc,
        output id_ready,
        input  id_valid,
        input  id_pc,
        input  id_inst,
        input  id_pc_plus4,
        input  id_fault,
        input  fetch_count
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch: PC, i_mem address, IF/ID register, redirect flush, sticky fault
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 100,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_unit_if.master  bus
);

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_fault;
    logic [31:0] r_fetch_count;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_id_valid_nxt;
    logic [31:0] w_id_pc_nxt;
    logic [31:0] w_id_inst_nxt;
    logic        w_id_fault_nxt;
    logic [31:0] w_fetch_count_nxt;
    logic        w_out_free;
    logic        w_bad;

    assign w_out_free = !r_id_valid || bus.id_ready;
    assign w_bad      = (r_pc[1:0] != 2'b00) || ({2'b00, r_pc[31:2]} >= DEPTH_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_pc       <= 32'h0;
            r_id_inst     <= NOP_INST;
            r_id_fault    <= 1'b0;
            r_fetch_count <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_id_inst     <= w_id_inst_nxt;
            r_id_fault    <= w_id_fault_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_id_valid_nxt    = r_id_valid;
        w_id_pc_nxt       = r_id_pc;
        w_id_inst_nxt     = r_id_inst;
        w_id_fault_nxt    = r_id_fault;
        w_fetch_count_nxt = r_fetch_count;

        // A redirect flushes the held entry, so its handshake is never counted.
        if (r_id_valid && bus.id_ready && !r_id_fault && !bus.redirect_valid)
            w_fetch_count_nxt = r_fetch_count + 32'd1;

        case (r_state)
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt       = bus.redirect_pc;
                    w_id_valid_nxt = 1'b0;
                end else if (w_out_free && !w_bad) begin
                    w_id_pc_nxt    = r_pc;
                    w_id_inst_nxt  = bus.imem_inst;
                    w_id_fault_nxt = 1'b0;
                    w_id_valid_nxt = 1'b1;
                    w_pc_nxt       = r_pc + 32'd4;
                end else if (w_out_free) begin
                    w_id_pc_nxt    = r_pc;
                    w_id_inst_nxt  = NOP_INST;
                    w_id_fault_nxt = 1'b1;
                    w_id_valid_nxt = 1'b1;
                    w_state_nxt    = ST_FAULT;
                end
            end
            ST_FAULT: begin
                // Parked on the faulting PC until a redirect supplies a new target.
                if (bus.redirect_valid) begin
                    w_pc_nxt       = bus.redirect_pc;
                    w_id_valid_nxt = 1'b0;
                    w_state_nxt    = ST_RUN;
                end else if (r_id_valid && bus.id_ready) begin
                    w_id_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign bus.imem_pc     = r_pc;
    assign bus.id_valid    = r_id_valid;
    assign bus.id_pc       = r_id_pc;
    assign bus.id_inst     = r_id_inst;
    assign bus.id_pc_plus4 = r_id_pc + 32'd4;
    assign bus.id_fault    = r_id_fault;
    assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] exp_count = 32'h0;
    entry_t sb[$];
    entry_t e;

    if_fetch_unit_if bus();

    if_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (100),
        .NOP_INST   (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: word k holds 0x100 + k.
    assign bus.imem_inst = 32'h100 + {2'b00, bus.imem_pc[31:2]};

    task automatic test_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %h want 0", bus.id_valid); end
        checks++; if (bus.id_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got %h want 0", bus.id_pc); end
        checks++; if (bus.id_pc_plus4 !== 32'h4) begin failures++; $display("FAIL reset_pc4 got %h want 4", bus.id_pc_plus4); end
        checks++; if (bus.id_inst !== NOP) begin failures++; $display("FAIL reset_inst got %h want %h", bus.id_inst, NOP); end
        checks++; if (bus.id_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got %h want 0", bus.id_fault); end
        checks++; if (bus.fetch_count !== 32'h0) begin failures++; $display("FAIL reset_count got %h want 0", bus.fetch_count); end
        checks++; if (bus.imem_pc !== 32'h0) begin failures++; $display("FAIL reset_imem_pc got %h want 0", bus.imem_pc); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        bus.id_ready = 1'b1;
        for (int k = 0; k < 2; k++) sb.push_back('{pc: 32'(4 * k), inst: 32'(32'h100 + k), fault: 1'b0});
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL stream_valid got %h want 1", bus.id_valid); end
            checks++; if (bus.id_pc !== e.pc) begin failures++; $display("FAIL stream_pc got %h want %h", bus.id_pc, e.pc); end
            checks++; if (bus.id_inst !== e.inst) begin failures++; $display("FAIL stream_inst got %h want %h", bus.id_inst, e.inst); end
            checks++; if (bus.id_pc_plus4 !== e.pc + 32'd4) begin failures++; $display("FAIL stream_pc4 got %h want %h", bus.id_pc_plus4, e.pc + 32'd4); end
            checks++; if (bus.id_fault !== e.fault) begin failures++; $display("FAIL stream_fault got %h want %h", bus.id_fault, e.fault); end
            checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL stream_count got %0d want %0d", bus.fetch_count, exp_count); end
            @(posedge clk); #1;
            exp_count++;
        end
    endtask

    task automatic test_stall();
        bus.id_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got %h want 1", bus.id_valid); end
            checks++; if (bus.id_pc !== 32'h8) begin failures++; $display("FAIL stall_pc got %h want 8", bus.id_pc); end
            checks++; if (bus.id_inst !== 32'h102) begin failures++; $display("FAIL stall_inst got %h want 102", bus.id_inst); end
            checks++; if (bus.imem_pc !== 32'hC) begin failures++; $display("FAIL stall_imem_pc got %h want c", bus.imem_pc); end
            checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL stall_count got %0d want %0d", bus.fetch_count, exp_count); end
        end
        bus.id_ready = 1'b1;
        sb.push_back('{pc: 32'h8,  inst: 32'h102, fault: 1'b0});
        sb.push_back('{pc: 32'hC,  inst: 32'h103, fault: 1'b0});
        sb.push_back('{pc: 32'h10, inst: 32'h104, fault: 1'b0});
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            checks++; if (bus.id_pc !== e.pc) begin failures++; $display("FAIL release_pc got %h want %h", bus.id_pc, e.pc); end
            checks++; if (bus.id_inst !== e.inst) begin failures++; $display("FAIL release_inst got %h want %h", bus.id_inst, e.inst); end
            checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL release_count got %0d want %0d", bus.fetch_count, exp_count); end
            if (k < 2) begin
                @(posedge clk); #1;
                exp_count++;
            end
        end
    endtask

    task automatic test_redirect();
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble got %h want 0", bus.id_valid); end
        checks++; if (bus.imem_pc !== 32'h40) begin failures++; $display("FAIL redir_imem_pc got %h want 40", bus.imem_pc); end
        checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL redir_count got %0d want %0d", bus.fetch_count, exp_count); end
        sb.push_back('{pc: 32'h40, inst: 32'h110, fault: 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL redir_valid got %h want 1", bus.id_valid); end
        checks++; if (bus.id_pc !== e.pc) begin failures++; $display("FAIL redir_pc got %h want %h", bus.id_pc, e.pc); end
        checks++; if (bus.id_inst !== e.inst) begin failures++; $display("FAIL redir_inst got %h want %h", bus.id_inst, e.inst); end
    endtask

    task automatic test_misaligned();
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h22;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL mis_bubble got %h want 0", bus.id_valid); end
        checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL mis_redir_count got %0d want %0d", bus.fetch_count, exp_count); end
        sb.push_back('{pc: 32'h22, inst: NOP, fault: 1'b1});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL mis_valid got %h want 1", bus.id_valid); end
        checks++; if (bus.id_pc !== e.pc) begin failures++; $display("FAIL mis_pc got %h want %h", bus.id_pc, e.pc); end
        checks++; if (bus.id_inst !== e.inst) begin failures++; $display("FAIL mis_inst got %h want %h", bus.id_inst, e.inst); end
        checks++; if (bus.id_fault !== e.fault) begin failures++; $display("FAIL mis_fault got %h want %h", bus.id_fault, e.fault); end
        repeat (5) begin
            @(posedge clk); #1;
            checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL mis_hold_valid got %h want 0", bus.id_valid); end
            checks++; if (bus.imem_pc !== 32'h22) begin failures++; $display("FAIL mis_hold_pc got %h want 22", bus.imem_pc); end
            checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL mis_hold_count got %0d want %0d", bus.fetch_count, exp_count); end
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h10;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        sb.push_back('{pc: 32'h10, inst: 32'h104, fault: 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL resume_valid got %h want 1", bus.id_valid); end
        checks++; if (bus.id_pc !== e.pc) begin failures++; $display("FAIL resume_pc got %h want %h", bus.id_pc, e.pc); end
        checks++; if (bus.id_inst !== e.inst) begin failures++; $display("FAIL resume_inst got %h want %h", bus.id_inst, e.inst); end
        checks++; if (bus.id_fault !== e.fault) begin failures++; $display("FAIL resume_fault got %h want %h", bus.id_fault, e.fault); end
    endtask

    task automatic test_out_of_range();
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h18C;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        sb.push_back('{pc: 32'h18C, inst: 32'h163, fault: 1'b0});
        sb.push_back('{pc: 32'h190, inst: NOP, fault: 1'b1});
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (k == 1) exp_count++;
            e = sb.pop_front();
            checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL oor_valid got %h want 1", bus.id_valid); end
            checks++; if (bus.id_pc !== e.pc) begin failures++; $display("FAIL oor_pc got %h want %h", bus.id_pc, e.pc); end
            checks++; if (bus.id_inst !== e.inst) begin failures++; $display("FAIL oor_inst got %h want %h", bus.id_inst, e.inst); end
            checks++; if (bus.id_fault !== e.fault) begin failures++; $display("FAIL oor_fault got %h want %h", bus.id_fault, e.fault); end
            checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL oor_count got %0d want %0d", bus.fetch_count, exp_count); end
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL oor_hold_valid got %h want 0", bus.id_valid); end
            checks++; if (bus.imem_pc !== 32'h190) begin failures++; $display("FAIL oor_hold_pc got %h want 190", bus.imem_pc); end
            checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL oor_hold_count got %0d want %0d", bus.fetch_count, exp_count); end
        end
    endtask

    task automatic test_async_reset();
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL arst_pre_valid got %h want 1", bus.id_valid); end
        checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL arst_pre_count got %0d want %0d", bus.fetch_count, exp_count); end
        #2;
        rst = 1'b1;
        #1;
        exp_count = 32'h0;
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got %h want 0", bus.id_valid); end
        checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL arst_count got %0d want 0", bus.fetch_count); end
        checks++; if (bus.id_fault !== 1'b0) begin failures++; $display("FAIL arst_fault got %h want 0", bus.id_fault); end
        checks++; if (bus.imem_pc !== 32'h0) begin failures++; $display("FAIL arst_imem_pc got %h want 0", bus.imem_pc); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.id_ready = 1'b1;
        sb.push_back('{pc: 32'h0, inst: 32'h100, fault: 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL arst_first_valid got %h want 1", bus.id_valid); end
        checks++; if (bus.id_pc !== e.pc) begin failures++; $display("FAIL arst_first_pc got %h want %h", bus.id_pc, e.pc); end
        checks++; if (bus.id_inst !== e.inst) begin failures++; $display("FAIL arst_first_inst got %h want %h", bus.id_inst, e.inst); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_out_of_range();
        test_async_reset();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
